// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI memory subsystem: master/slave state encodings and command bits.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDATA, WAIT_DONE, RESP, ERR
  } master_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WRITE, S_READ, S_SEND, S_DONE
  } slave_state_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_mem_slave.sv
// SPI slave with word memory: receives cmd/addr(/wdata) LSB first, writes or shifts read data out.
// Latency: write commits ADDR_W+DATA_W+2 edges after cs falls; read data starts ADDR_W+2 edges after.
// Backpressure: none; follows the master bit-for-bit and pulses o_op_done once per frame.
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_op_done
);
  localparam int CNT_W  = $clog2(ADDR_W + DATA_W + 1);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  slave_state_e        r_state, w_next;
  logic                r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_op_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [MEM_AW-1:0]   w_idx;
  logic                w_in_range;

  // The master never sends an out-of-range address; the guard keeps a stray one harmless.
  assign w_idx      = r_addr[MEM_AW-1:0];
  assign w_in_range = ({1'b0, r_addr} < DEPTH_V);
  assign o_miso     = (r_state == S_SEND) ? r_data[0] : 1'b0;
  assign o_op_done  = r_op_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state: walk the frame fields; cs rising early abandons the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!i_cs) w_next = S_CMD;
      S_CMD:   w_next = S_ADDR;
      S_ADDR:  if (r_cnt == ADDR_LAST) w_next = (r_cmd == CMD_WR) ? S_WDATA : S_READ;
      S_WDATA: if (r_cnt == DATA_LAST) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_READ:  w_next = S_SEND;
      S_SEND:  if (r_cnt == DATA_LAST) w_next = S_DONE;
      S_DONE:  if (i_cs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_cs && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Shift registers, bit counter, memory and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_op_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_op_done <= 1'b0;
      case (r_state)
        S_IDLE:  r_cmd <= i_mosi;
        S_CMD: begin
          r_addr <= (r_addr >> 1) | (ADDR_W'(i_mosi) << (ADDR_W - 1));
          r_cnt  <= CNT_W'(1);
        end
        S_ADDR: begin
          r_addr <= (r_addr >> 1) | (ADDR_W'(i_mosi) << (ADDR_W - 1));
          r_cnt  <= (r_cnt == ADDR_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_WDATA: begin
          r_data <= (r_data >> 1) | (DATA_W'(i_mosi) << (DATA_W - 1));
          r_cnt  <= r_cnt + 1'b1;
        end
        S_WRITE: begin
          if (w_in_range) r_mem[w_idx] <= r_data;
          r_op_done <= 1'b1;
        end
        S_READ: begin
          r_data <= w_in_range ? r_mem[w_idx] : '0;
          r_cnt  <= '0;
        end
        S_SEND: begin
          r_data <= r_data >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == DATA_LAST) r_op_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_mem_sys.sv
// Host request/response front end plus SPI master driving an on-chip SPI slave memory.
// Latency: response ADDR_W+DATA_W+3 edges after accept; range errors respond after 1 edge.
// Backpressure: response held until rsp_ready; one request in flight. Option: SPI_MEM_STATS_EN adds op counters.
module spi_mem_sys
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef SPI_MEM_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt
`endif
);
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // Read data arrives two edges after the last address bit leaves the master.
  localparam logic [CNT_W-1:0] RD_FIRST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DATA_W + 1);
  localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  master_state_e              r_state, w_next;
  logic                       r_wr;
  logic [ADDR_W+DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]          r_rx;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_cs;
  logic                       r_mosi;
  logic [DATA_W-1:0]          r_rdata;
  logic                       r_err;
  logic                       w_oor;
  logic                       w_miso;
  logic                       w_op_done;

  assign w_oor     = ({1'b0, req_addr} >= DEPTH_V);
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  spi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_slave (
    .clk       (clk),
    .rst       (rst),
    .i_cs      (r_cs),
    .i_mosi    (r_mosi),
    .o_miso    (w_miso),
    .o_op_done (w_op_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state: frame sequencing, range-error shortcut and response handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (req_valid) w_next = w_oor ? ERR : CMD;
      CMD:       w_next = ADDR;
      ADDR:      if (r_cnt == ADDR_LAST) w_next = (r_wr == CMD_WR) ? WDATA : RDATA;
      WDATA:     if (r_cnt == DATA_LAST) w_next = WAIT_DONE;
      RDATA:     if (r_cnt == RD_LAST) w_next = WAIT_DONE;
      WAIT_DONE: if (w_op_done) w_next = RESP;
      ERR:       w_next = RESP;
      RESP:      if (rsp_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Link datapath: cs/mosi drive, read capture, response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_cnt   <= '0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_wr <= req_wr;
          r_tx <= {req_wdata, req_addr};
          if (!w_oor) begin
            r_cs   <= 1'b0;
            r_mosi <= req_wr ? CMD_WR : CMD_RD;
          end
        end
        CMD: begin
          r_mosi <= r_tx[0];
          r_tx   <= r_tx >> 1;
          r_cnt  <= CNT_W'(1);
        end
        ADDR: begin
          r_mosi <= r_tx[0];
          r_tx   <= r_tx >> 1;
          r_cnt  <= (r_cnt == ADDR_LAST) ? '0 : r_cnt + 1'b1;
        end
        WDATA: begin
          r_mosi <= r_tx[0];
          r_tx   <= r_tx >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        RDATA: begin
          r_mosi <= 1'b0;
          if (r_cnt >= RD_FIRST) r_rx <= (r_rx >> 1) | (DATA_W'(w_miso) << (DATA_W - 1));
          r_cnt  <= r_cnt + 1'b1;
        end
        WAIT_DONE: begin
          r_mosi <= 1'b0;
          if (w_op_done) begin
            r_cs    <= 1'b1;
            r_rdata <= (r_wr == CMD_WR) ? '0 : r_rx;
            r_err   <= 1'b0;
          end
        end
        ERR: begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_MEM_STATS_EN
  // Operation counters, bumped on the response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else if ((r_state == RESP) && rsp_ready) begin
      if (r_err)                err_cnt <= sat_inc16(err_cnt);
      else if (r_wr == CMD_WR)  wr_cnt  <= sat_inc16(wr_cnt);
      else                      rd_cnt  <= sat_inc16(rd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_spi_mem_sys.sv
// Bench for spi_mem_sys: two builds (8/8/128 and 10/16/1000) against an array-based memory model.
// Latency: expected response delay derived from frame length (ADDR_W+DATA_W+3, or 1 on range error).
// Backpressure: random rsp_ready hold-off with stability checks during the hold.
module tb_spi_mem_sys;
  localparam int A0 = 8,  D0 = 8,  N0 = 128;
  localparam int A1 = 10, D1 = 16, N1 = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid0, req_ready0, req_wr0, rsp_valid0, rsp_ready0, rsp_err0, busy0;
  logic [A0-1:0] req_addr0;
  logic [D0-1:0] req_wdata0, rsp_rdata0;
  logic          req_valid1, req_ready1, req_wr1, rsp_valid1, rsp_ready1, rsp_err1, busy1;
  logic [A1-1:0] req_addr1;
  logic [D1-1:0] req_wdata1, rsp_rdata1;
`ifdef SPI_MEM_STATS_EN
  logic [15:0] wr_cnt0, rd_cnt0, err_cnt0, wr_cnt1, rd_cnt1, err_cnt1;
`endif

  spi_mem_sys #(.ADDR_W(A0), .DATA_W(D0), .DEPTH(N0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
`ifdef SPI_MEM_STATS_EN
    , .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0), .err_cnt(err_cnt0)
`endif
  );

  spi_mem_sys #(.ADDR_W(A1), .DATA_W(D1), .DEPTH(N1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
`ifdef SPI_MEM_STATS_EN
    , .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1), .err_cnt(err_cnt1)
`endif
  );

  // Reference model: plain word arrays plus tallies of completed operations on build 0.
  logic [31:0] mem0 [N0];
  logic [31:0] mem1 [N1];
  int t_wr, t_rd, t_err;
  int checks = 0, errors = 0;

  int          sel_g = 0;
  logic        cur_ready, cur_valid, cur_err, cur_busy, cur_cs;
  logic [31:0] cur_rdata;

  always_comb begin
    if (sel_g == 0) begin
      cur_ready = req_ready0; cur_valid = rsp_valid0; cur_err = rsp_err0;
      cur_busy  = busy0;      cur_rdata = 32'(rsp_rdata0); cur_cs = u_dut0.r_cs;
    end else begin
      cur_ready = req_ready1; cur_valid = rsp_valid1; cur_err = rsp_err1;
      cur_busy  = busy1;      cur_rdata = 32'(rsp_rdata1); cur_cs = u_dut1.r_cs;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N0; i++) mem0[i] = '0;
    for (int i = 0; i < N1; i++) mem1[i] = '0;
    t_wr = 0; t_rd = 0; t_err = 0;
  endtask

  // One complete request/response with the response held off for 'hold' cycles.
  task automatic run_op(input int sel, input bit wr, input int addr, input logic [31:0] data, input int hold);
    int n, lat, depth, exp_lat;
    bit cs_low, exp_err;
    logic [31:0] exp_rd, mask;
    depth   = (sel == 0) ? N0 : N1;
    mask    = (sel == 0) ? 32'hFF : 32'hFFFF;
    exp_lat = (sel == 0) ? (A0 + D0 + 3) : (A1 + D1 + 3);
    exp_err = (addr >= depth);
    if (exp_err) begin exp_rd = '0; exp_lat = 1; end
    else if (wr) exp_rd = '0;
    else exp_rd = (sel == 0) ? mem0[addr] : mem1[addr];
    sel_g = sel;
    @(negedge clk);
    if (sel == 0) begin
      req_valid0 = 1'b1; req_wr0 = wr; req_addr0 = A0'(addr); req_wdata0 = D0'(data);
    end else begin
      req_valid1 = 1'b1; req_wr1 = wr; req_addr1 = A1'(addr); req_wdata1 = D1'(data);
    end
    n = 0;
    while (!cur_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before_accept", cur_ready, 1'b1);
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    lat = 0; cs_low = 1'b0;
    while (!cur_valid && lat < 100) begin
      if (!cur_cs) cs_low = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", cur_rdata, exp_rd);
    chk("rsp_err", cur_err, exp_err);
    chk("cs_low_in_frame", cs_low, !exp_err);
    chk("cs_high_at_rsp", cur_cs, 1'b1);
    if (!exp_err && wr) begin
      if (sel == 0) mem0[addr] = data & mask;
      else          mem1[addr] = data & mask;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", cur_valid, 1'b1);
      chk("hold_rdata", cur_rdata, exp_rd);
      chk("hold_err", cur_err, exp_err);
      chk("hold_req_ready", cur_ready, 1'b0);
    end
    @(negedge clk);
    if (sel == 0) rsp_ready0 = 1'b1; else rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    chk("post_hs_valid", cur_valid, 1'b0);
    chk("post_hs_req_ready", cur_ready, 1'b1);
    chk("post_hs_busy", cur_busy, 1'b0);
    if (sel == 0) begin
      if (exp_err) t_err++;
      else if (wr) t_wr++;
      else t_rd++;
    end
  endtask

  initial begin
    req_valid0 = 0; req_wr0 = 0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 0;
    req_valid1 = 0; req_wr1 = 0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 0;
    clear_model();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_req_ready", req_ready0, 1'b1);
    chk("rst_rsp_valid", rsp_valid0, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata0, 8'h00);
    chk("rst_rsp_err", rsp_err0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_cs", u_dut0.r_cs, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases on the 8/8/128 build.
    run_op(0, 1'b1, 'h05, 32'h3C, 0);
    run_op(0, 1'b0, 'h05, 32'h0, 0);
    run_op(0, 1'b0, 'h7F, 32'h0, 0);
    run_op(0, 1'b1, 'h80, 32'h55, 0);
    run_op(0, 1'b0, 'h80, 32'h0, 0);
    run_op(0, 1'b0, 'h05, 32'h0, 10);

    // Reset in the middle of a write frame.
    sel_g = 0;
    @(negedge clk);
    req_valid0 = 1'b1; req_wr0 = 1'b1; req_addr0 = 8'h11; req_wdata0 = 8'hA5;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready0, 1'b1);
    chk("midrst_rsp_valid", rsp_valid0, 1'b0);
    chk("midrst_rsp_rdata", rsp_rdata0, 8'h00);
    chk("midrst_rsp_err", rsp_err0, 1'b0);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_cs", u_dut0.r_cs, 1'b1);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    run_op(0, 1'b0, 'h11, 32'h0, 0);

    // Random traffic, biased toward a few addresses so reads hit earlier writes.
    for (int k = 0; k < 40; k++) begin
      int a;
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(N0, 255);
        1:       a = $urandom_range(0, N0 - 1);
        default: a = $urandom_range(0, 7);
      endcase
      run_op(0, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    // Wide build: top in-range address, first out-of-range address, then random.
    run_op(1, 1'b1, 999, 32'hBEEF, 0);
    run_op(1, 1'b0, 999, 32'h0, 0);
    run_op(1, 1'b0, 1000, 32'h0, 0);
    run_op(1, 1'b1, 1000, 32'h1234, 1);
    for (int k = 0; k < 12; k++) begin
      run_op(1, 1'($urandom_range(0, 1)), $urandom_range(990, 1023), $urandom, $urandom_range(0, 2));
    end

`ifdef SPI_MEM_STATS_EN
    chk("wr_cnt", wr_cnt0, t_wr);
    chk("rd_cnt", rd_cnt0, t_rd);
    chk("err_cnt", err_cnt0, t_err);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
